// File: rtl/timer_sequencer_host.sv
`default_nettype none
// ============================================================================
// timer_sequencer_host: programs a prescaled timer, counts compare matches and
// reports one status per command. Optional abort: TIMER_SEQ_ABORT_EN. Rev 1.0
// ============================================================================
module timer_sequencer_host #(
  parameter int TIMER_WIDTH   = 16,
  parameter int COUNT_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 24,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [TIMER_WIDTH-1:0] cmd_load,
  input  logic [TIMER_WIDTH-1:0] cmd_compare,
  input  logic [COUNT_WIDTH-1:0] cmd_repeat,
  input  logic                   abort,
  output logic [TIMER_WIDTH-1:0] timer_load,
  output logic [TIMER_WIDTH-1:0] compare_value,
  output logic                   timer_enable,
  output logic                   timer_reset,
  input  logic                   timer_overflow,
  input  logic                   timer_match,
  input  logic                   timer_active,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             status,
  output logic [COUNT_WIDTH-1:0] match_count
);

  localparam logic [2:0] STAT_NONE     = 3'b000;
  localparam logic [2:0] STAT_COMPLETE = 3'b001;
  localparam logic [2:0] STAT_OVERFLOW = 3'b010;
  localparam logic [2:0] STAT_TIMEOUT  = 3'b011;
  localparam logic [2:0] STAT_ABORT    = 3'b100;
  localparam logic [2:0] STAT_LOST     = 3'b101;

  localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LAST = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [TIMER_WIDTH-1:0]   load_q, compare_q;
  logic [COUNT_WIDTH-1:0]   target_q, count_q;
  logic [2:0]               status_q, status_nxt;
  logic [TIMEOUT_WIDTH-1:0] wdog_q;
  logic                     seen_active_q, inactive_q, match_prev_q;
  logic                     accept, match_edge, repeat_hit, lost, abort_req;

`ifdef TIMER_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_req    = 1'b0;
`endif

  assign accept     = (state == S_IDLE) && cmd_valid;
  assign match_edge = timer_match && !match_prev_q;
  assign repeat_hit = match_edge &&
                      (({1'b0, count_q} + (COUNT_WIDTH+1)'(1)) == {1'b0, target_q});
  // inactive_q marks that the previous WAIT cycle was already idle after activity
  assign lost       = seen_active_q && inactive_q && !timer_active;

  always_comb begin
    state_nxt  = state;
    status_nxt = status_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt  = S_ARM;
          status_nxt = STAT_NONE;
        end
      end
      S_ARM: begin
        if (abort_req) begin
          state_nxt  = S_STOP;
          status_nxt = STAT_ABORT;
        end else begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (abort_req) begin
          state_nxt  = S_STOP;
          status_nxt = STAT_ABORT;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (timer_overflow) begin
          state_nxt  = S_STOP;
          status_nxt = STAT_OVERFLOW;
        end else if (repeat_hit) begin
          state_nxt  = S_STOP;
          status_nxt = STAT_COMPLETE;
        end else if (abort_req) begin
          state_nxt  = S_STOP;
          status_nxt = STAT_ABORT;
        end else if (lost) begin
          state_nxt  = S_STOP;
          status_nxt = STAT_LOST;
        end else if (wdog_q == WDOG_LAST) begin
          state_nxt  = S_STOP;
          status_nxt = STAT_TIMEOUT;
        end
      end
      S_STOP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      status_q      <= STAT_NONE;
      load_q        <= '0;
      compare_q     <= '0;
      target_q      <= '0;
      count_q       <= '0;
      wdog_q        <= '0;
      seen_active_q <= 1'b0;
      inactive_q    <= 1'b0;
      match_prev_q  <= 1'b0;
    end else begin
      state        <= state_nxt;
      status_q     <= status_nxt;
      match_prev_q <= timer_match;
      if (accept) begin
        load_q        <= cmd_load;
        compare_q     <= cmd_compare;
        target_q      <= (cmd_repeat == '0) ? COUNT_WIDTH'(1) : cmd_repeat;
        count_q       <= '0;
        wdog_q        <= '0;
        seen_active_q <= 1'b0;
        inactive_q    <= 1'b0;
      end
      if (state == S_WAIT) begin
        wdog_q     <= wdog_q + TIMEOUT_WIDTH'(1);
        inactive_q <= seen_active_q && !timer_active;
        if (timer_active) seen_active_q <= 1'b1;
        if (match_edge && (count_q != '1)) count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign cmd_ready     = (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign timer_reset   = (state == S_ARM);
  assign timer_enable  = (state == S_START) || (state == S_WAIT);
  assign done          = (state == S_STOP);
  assign timer_load    = load_q;
  assign compare_value = compare_q;
  assign status        = status_q;
  assign match_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_sequencer_host.sv
`default_nettype none
// tb_timer_sequencer_host: randomized timer-event scripts checked against an
// outcome model that scans each script for the first terminating event.
module tb_timer_sequencer_host;

  localparam int TW   = 16;
  localparam int CW   = 8;
  localparam int TOW  = 24;
  localparam int TO   = 50;
  localparam int SLEN = 56;
`ifdef TIMER_SEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [TW-1:0] cmd_load = '0;
  logic [TW-1:0] cmd_compare = '0;
  logic [CW-1:0] cmd_repeat = '0;
  logic          abort = 1'b0;
  logic [TW-1:0] timer_load, compare_value;
  logic          timer_enable, timer_reset;
  logic          timer_overflow = 1'b0;
  logic          timer_match = 1'b0;
  logic          timer_active = 1'b0;
  logic          busy, done;
  logic [2:0]    status;
  logic [CW-1:0] match_count;

  always #5 clk = ~clk;

  timer_sequencer_host #(
    .TIMER_WIDTH(TW), .COUNT_WIDTH(CW), .TIMEOUT_WIDTH(TOW), .TIMEOUT_CYCLES(24'd50)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_compare(cmd_compare), .cmd_repeat(cmd_repeat),
    .abort(abort), .timer_load(timer_load), .compare_value(compare_value),
    .timer_enable(timer_enable), .timer_reset(timer_reset),
    .timer_overflow(timer_overflow), .timer_match(timer_match),
    .timer_active(timer_active), .busy(busy), .done(done), .status(status),
    .match_count(match_count)
  );

  int checks = 0;
  int errors = 0;

  // Per-WAIT-cycle timer/abort script, index 0 = first WAIT cycle
  bit m_s [SLEN];
  bit o_s [SLEN];
  bit a_s [SLEN];
  bit ab_s[SLEN];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_script;
    for (int i = 0; i < SLEN; i++) begin
      m_s[i] = 1'b0; o_s[i] = 1'b0; a_s[i] = 1'b0; ab_s[i] = 1'b0;
    end
  endtask

  task automatic gen_script(input int mode);
    int pos;
    pos = $urandom_range(2, SLEN - 10);
    for (int i = 0; i < SLEN; i++) begin
      m_s[i]  = (mode != 2) && ($urandom_range(0, 5) == 0);
      o_s[i]  = (mode == 1) && (i == pos);
      ab_s[i] = (mode == 4) && (i == pos);
      if (mode == 3) a_s[i] = (i < pos) || ($urandom_range(0, 3) == 0);
      else           a_s[i] = ($urandom_range(0, 9) != 0);
    end
  endtask

  // Outcome model: first WAIT cycle whose events end the command, by priority
  task automatic predict(input int rpt, output int xi, output logic [2:0] st, output int mc);
    int target, edges;
    bit prev_m, edge_now, active_early, lost;
    target = (rpt == 0) ? 1 : rpt;
    edges  = 0;
    prev_m = 1'b0;
    xi     = SLEN - 1;
    st     = 3'b011;
    mc     = 0;
    for (int i = 0; i < SLEN; i++) begin
      edge_now = m_s[i] && !prev_m;
      prev_m   = m_s[i];
      lost     = 1'b0;
      if (i >= 2) begin
        active_early = 1'b0;
        for (int j = 0; j <= i - 2; j++) active_early |= a_s[j];
        lost = active_early && !a_s[i] && !a_s[i-1];
      end
      st = 3'b000;
      if (o_s[i])                              st = 3'b010;
      else if (edge_now && edges + 1 == target) st = 3'b001;
      else if (ABORT_EN && ab_s[i])            st = 3'b100;
      else if (lost)                           st = 3'b101;
      else if (i == TO - 1)                    st = 3'b011;
      if (edge_now && edges < 255) edges++;
      if (st != 3'b000) begin
        xi = i;
        mc = edges;
        break;
      end
    end
  endtask

  task automatic drive_wait(input int i);
    if (i >= 0) begin
      timer_match = m_s[i]; timer_overflow = o_s[i];
      timer_active = a_s[i]; abort = ab_s[i];
    end else begin
      timer_match = 1'b0; timer_overflow = 1'b0;
      timer_active = 1'b0; abort = 1'b0;
    end
  endtask

  task automatic run_cmd(input logic [TW-1:0] ld, input logic [TW-1:0] cmp, input int rpt,
                         output logic [2:0] st_out);
    int x, mc, enable_bad, early_done;
    logic [2:0] st;
    bit exp_en;
    predict(rpt, x, st, mc);
    st_out = st;
    check("ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_load = ld; cmd_compare = cmp; cmd_repeat = CW'(rpt);
    drive_wait(-1);
    tick;
    // junk commands while busy must be ignored
    cmd_valid = 1'(($urandom_range(0, 1)));
    cmd_load = TW'($urandom); cmd_compare = TW'($urandom); cmd_repeat = CW'($urandom);
    check("arm_pins", 32'({timer_reset, timer_enable, busy, cmd_ready, done}), 32'b10100);
    check("latched_values", {timer_load, compare_value}, {ld, cmp});
    enable_bad = 0;
    early_done = 0;
    for (int t = 1; t <= x + 3; t++) begin
      tick;
      exp_en = (t <= x + 2);
      if (timer_enable !== exp_en) enable_bad++;
      if (timer_reset !== 1'b0) enable_bad++;
      if (t == 1) check("enable_latency", 32'(timer_enable), 32'd1);
      if (t < x + 3 && done === 1'b1) early_done++;
      if (t == x + 3) begin
        check("done_pulse", 32'(done), 32'd1);
        check("status_stop", 32'(status), 32'(st));
        check("match_count", 32'(match_count), 32'(mc));
        check("values_held", {timer_load, compare_value}, {ld, cmp});
        cmd_valid = 1'b0;
      end
      if (t >= 2 && t <= x + 2) drive_wait(t - 2);
      else                      drive_wait(-1);
    end
    tick;
    check("enable_profile", 32'(enable_bad), 32'd0);
    check("early_done", 32'(early_done), 32'd0);
    check("idle_pins", 32'({busy, cmd_ready, done, timer_enable}), 32'b0100);
    check("status_hold", {8'(status), 8'(match_count), 16'(timer_load)}, {8'(st), 8'(mc), ld});
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int dcount;
    logic [2:0] st;

    // Reset phase
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (done === 1'b1) dcount++;
    end
    check("reset_done_never", 32'(dcount), 32'd0);
    check("reset_ctrl", 32'({cmd_ready, busy, timer_enable, timer_reset, done, status}), 32'b10_0000_00);
    check("reset_data", {timer_load, compare_value}, 32'd0);
    check("reset_count", 32'(match_count), 32'd0);
    rst = 1'b1;
    tick;

    // Normal run: first match completes
    clear_script();
    for (int i = 0; i < SLEN; i++) a_s[i] = 1'b1;
    m_s[3] = 1'b1;
    run_cmd(16'h0000, 16'h0003, 1, st);
    check("normal_status", 32'(status), 32'd1);

    // Overflow and match coincide: overflow wins
    clear_script();
    for (int i = 0; i < SLEN; i++) a_s[i] = 1'b1;
    m_s[4] = 1'b1; o_s[4] = 1'b1;
    run_cmd(16'hFFFE, 16'h0000, 2, st);
    check("overflow_wins", 32'(status), 32'd2);

    // Timeout: never matches
    clear_script();
    for (int i = 0; i < SLEN; i++) a_s[i] = 1'b1;
    run_cmd(16'h0100, 16'h0200, 3, st);
    check("timeout_status", 32'(status), 32'd3);

    // Lost activity after one match
    clear_script();
    for (int i = 0; i < 8; i++) a_s[i] = 1'b1;
    m_s[3] = 1'b1;
    run_cmd(16'h0010, 16'h0020, 3, st);
    check("lost_status", {8'(status), 8'(match_count)}, {8'd5, 8'd1});

    // Repeat 0 behaves as 1
    clear_script();
    for (int i = 0; i < SLEN; i++) a_s[i] = 1'b1;
    m_s[2] = 1'b1; m_s[3] = 1'b1;
    run_cmd(16'h0001, 16'h0002, 0, st);
    check("repeat_zero", 32'(status), 32'd1);

    // Abort in WAIT, then a match later
    clear_script();
    for (int i = 0; i < SLEN; i++) a_s[i] = 1'b1;
    ab_s[5] = 1'b1; m_s[10] = 1'b1;
    run_cmd(16'h0003, 16'h0004, 1, st);
    check("abort_behaviour", 32'(status), ABORT_EN ? 32'd4 : 32'd1);

    // Randomized commands
    for (int k = 0; k < 30; k++) begin
      gen_script(int'($urandom_range(0, 4)));
      run_cmd(TW'($urandom), TW'($urandom), int'($urandom_range(0, 4)), st);
    end

    // Reset in the middle of WAIT
    clear_script();
    drive_wait(-1);
    cmd_valid = 1'b1; cmd_load = 16'h1234; cmd_compare = 16'h0010; cmd_repeat = 8'd5;
    tick;
    cmd_valid = 1'b0;
    tick;
    tick;
    timer_active = 1'b1; timer_match = 1'b1;
    tick;
    timer_match = 1'b0;
    tick;
    tick;
    check("midwait_count", 32'(match_count), 32'd1);
    check("midwait_enable", 32'(timer_enable), 32'd1);
    rst = 1'b0;
    tick;
    check("midwait_reset_pins", 32'({timer_enable, busy, done, cmd_ready}), 32'b0001);
    check("midwait_reset_count", 32'(match_count), 32'd0);
    rst = 1'b1; timer_active = 1'b0;
    dcount = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (done === 1'b1) dcount++;
    end
    check("midwait_no_done", 32'(dcount), 32'd0);
    check("midwait_status", 32'(status), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/timer_sequencer_host.md
Name: timer_sequencer_host

Overview:
- Command-driven initiator for the 16-bit prescaled timer. It programs the timer's load and compare values, generates the enable rising edge the timer requires, and counts compare-match pulses until a requested repeat count is reached.
- It watches timer overflow, unexpected loss of timer activity and a watchdog timeout, then reports one completion status per command.
- Sits between the control-plane command source and the timer's control/status pins.

Parameters:
- TIMER_WIDTH, 16, width of load/compare/timer values.
- COUNT_WIDTH, 8, width of repeat count and match counter.
- TIMEOUT_WIDTH, 24, width of watchdog counter.
- TIMEOUT_CYCLES, 24'd1000000, clock cycles in WAIT before declaring timeout.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_load  in  TIMER_WIDTH  timer start value.
- cmd_compare  in  TIMER_WIDTH  compare value.
- cmd_repeat  in  COUNT_WIDTH  matches to collect; 0 treated as 1.
- abort  in  1  abort request (see Optional Feature).
- timer_load  out  TIMER_WIDTH  to timer, latched cmd_load.
- compare_value  out  TIMER_WIDTH  to timer, latched cmd_compare.
- timer_enable  out  1  to timer.
- timer_reset  out  1  to timer.
- timer_overflow  in  1  from timer, one-cycle pulse.
- timer_match  in  1  from timer, one-cycle pulse.
- timer_active  in  1  from timer.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle completion pulse.
- status  out  3  000 none, 001 complete, 010 overflow, 011 timeout, 100 abort, 101 lost.
- match_count  out  COUNT_WIDTH  matches seen in last/current command.

Behaviour:
- Reset (rst==0 at posedge): state=IDLE. All outputs 0 except cmd_ready=1. Latched registers cleared; watchdog and seen_active cleared. Reset mid-command drops timer_enable the next cycle and produces no done pulse.
- IDLE: on handshake, latch load/compare/repeat (repeat 0 -> 1), clear match_count and status, go ARM.
- ARM (1 cycle): timer_reset=1, timer_enable=0. Go START.
- START (1 cycle): timer_enable=1, timer_reset=0. Go WAIT.
- WAIT: timer_enable=1. Watchdog increments each cycle. seen_active sets when timer_active==1.
  - Rising edge of timer_match (match==1, previous sample 0) increments match_count, saturating at all-ones.
  - Exit conditions, in priority order (only the highest applies in a cycle):
    1. timer_overflow -> status 010.
    2. match_count+1 == repeat on a match edge -> status 001.
    3. abort -> status 100.
    4. seen_active and timer_active==0 for 2 consecutive cycles -> status 101.
    5. watchdog == TIMEOUT_CYCLES-1 -> status 011.
  - Every exit goes to STOP.
- STOP (1 cycle): timer_enable=0, done=1, status registered. Go IDLE.
- Enable low for at least ARM+STOP between commands guarantees a fresh rising edge at the timer.
- timer_load/compare_value are held constant from ARM through STOP and retain their value in IDLE.
- status and match_count hold until the next accepted command.
- Command latency: handshake -> timer_enable high is 2 cycles. Completing event -> done is 1 cycle.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Optional Feature:
- Macro: TIMER_SEQ_ABORT_EN.
- Defined: abort is honoured in ARM, START and WAIT (priority as above; in ARM/START it goes directly to STOP with status 100).
- Undefined: the abort port exists but is ignored, and status 100 never occurs.

Test Plan:
- Reset then idle: rst=0 for 3 cycles -> cmd_ready=1, busy=0, timer_enable=0, status=000, done never pulses.
- Normal run: load=0x0000, compare=0x0003, repeat=1 -> timer_reset pulse, timer_enable high 2 cycles after handshake. On first match: done pulse, status=001, match_count=1, enable low in STOP.
- Overflow: load=0xFFFE, compare=0x0000, repeat=2 -> overflow pulse ends the command with status=010. If overflow and match occur in the same cycle, status=010.
- Timeout: TIMEOUT_CYCLES=50, timer model never matches -> done at cycle 50 of WAIT, status=011.
- Lost activity: timer model drops timer_active for 2 cycles after being active -> status=101, match_count unchanged. Also: rst low mid-WAIT -> IDLE and enable=0 with no done pulse.
- Abort (macro defined): abort=1 in WAIT -> status=100. Macro undefined, same stimulus -> command continues to status=001.
